store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Memory-write counterpart of the load path.
- Executes SB/SH/SW: computes the effective address from rs1_val+imm and stalls the PC while the access runs.
- Sub-word stores use a read-modify-write (RMW) sequence because the data memory has no byte enables. SW is a single full-word write.
- Sits beside the load unit on the same single-port synchronous data memory: 1-cycle read latency, mem_rw_mode 1=read, 0=write.

Parameters:
ERR_ON_MISALIGN, 1, 1: misaligned store raises misalign_err and is dropped; 0: address low bits are truncated to natural alignment and the store proceeds.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-low
rs1_val  input  32  base address operand
rs2_val  input  32  store data operand
imm  input  32  sign-extended S-type immediate
store_control  input  2  shared defines: ST_NOP=00, SB=01, SH=10, SW=11
mem_rdata  input  32  memory read data, valid 1 cycle after a read address
stall_pc  output  1  hold PC/fetch
ignore_curr_inst  output  1  squash the instruction presented this cycle
mem_rw_mode  output  1  1=read, 0=write (write commits on the clock edge)
mem_addr  output  32  word-aligned address {ea[31:2],2'b00}
mem_wdata  output  32  write data, meaningful only when mem_rw_mode=0
misalign_err  output  1  single-cycle pulse on a rejected store

Behaviour:
- ea = rs1_val + imm, modulo 2^32; wrap-around is legal.
- Registered state: state, ea_s, data_s (rs2_val), ctl_s, merge_s (32-bit).
- FSM states: IDLE, MERGE, WRITE.
- Inputs are sampled only in IDLE and ignored in MERGE/WRITE.
- Misaligned: SH with ea[0]=1, or SW with ea[1:0]!=0.
- IDLE, store_control=ST_NOP:
  - stall_pc=0, ignore_curr_inst=0, mem_rw_mode=1, mem_addr=0, mem_wdata=0, misalign_err=0.
  - Stay in IDLE.
- IDLE, misaligned store with ERR_ON_MISALIGN=1:
  - misalign_err=1 (combinational, same cycle), stall_pc=0, no memory write.
  - Stay in IDLE.
- IDLE, valid SB/SH:
  - stall_pc=1, mem_rw_mode=1, mem_addr=aligned ea.
  - Capture ea_s, data_s, ctl_s; go to MERGE.
- IDLE, valid SW:
  - stall_pc=1, mem_rw_mode=1, mem_addr=aligned ea.
  - Capture ea_s, data_s, ctl_s; merge_s<=rs2_val; go to WRITE.
- MERGE:
  - stall_pc=1, ignore_curr_inst=1, mem_rw_mode=1, mem_addr={ea_s[31:2],2'b00}.
  - merge_s <= mem_rdata with a lane replaced.
  - SB: byte ea_s[1:0] replaced by data_s[7:0].
  - SH: half ea_s[1] replaced by data_s[15:0].
  - Go to WRITE.
- WRITE:
  - stall_pc=0, ignore_curr_inst=1, mem_rw_mode=0, mem_addr={ea_s[31:2],2'b00}, mem_wdata=merge_s.
  - Go to IDLE unconditionally.
- Latency:
  - SW: 2 cycles (IDLE, WRITE).
  - SB/SH: 3 cycles (IDLE, MERGE, WRITE).
  - Exactly one write cycle per store; the PC advances at the end of WRITE.
- Back-to-back: a store presented in the cycle after WRITE is accepted normally; there are no dead cycles.
- Reset, including mid-operation:
  - state=IDLE; ea_s, data_s, ctl_s, merge_s all 0.
  - All outputs take their IDLE/NOP values immediately.
  - No write is issued for the aborted store.
- ERR_ON_MISALIGN=0: ea low bits forced to 0 (SH: bit 0; SW: bits 1:0); the store proceeds as aligned; misalign_err stays 0.

Test Plan:
1. SW, rs1=0xFC, imm=4, rs2=0xDEADBEEF
   -> cycle0 stall=1, read addr 0x100; cycle1 rw=0, addr 0x100, wdata 0xDEADBEEF, stall=0, ignore=1; cycle2 IDLE.
2. SB, mem[0x200]=0x11223344, ea=0x202, rs2=0xAB
   -> MERGE in cycle1; cycle2 writes 0x11AB3344 to 0x200; stall high for cycles 0–1 only.
3. SH, mem[0x200]=0x11223344, ea=0x202, rs2=0x1234BEEF
   -> writes 0xBEEF3344. With ea=0x200 and the same data -> writes 0x1122BEEF.
4. SW at ea=0x102 (ERR_ON_MISALIGN=1)
   -> misalign_err=1 for 1 cycle, stall_pc=0, no rw=0 cycle. With ERR_ON_MISALIGN=0 -> write to 0x100.
5. SB with rs1=0xFFFFFFFC, imm=8
   -> RMW on word 0x00000004, lane 0 replaced.
6. i_rst low during MERGE
   -> outputs reset that cycle, no write ever issued. A following SW after release completes normally in 2 cycles.

Source files
------------

// File: rtl/store_unit_if.sv
// Bundle between the store unit, the core front end and the shared data memory.
// The master side supplies the instruction operands and memory read data.
interface store_unit_if;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [1:0]  store_control;
    logic [31:0] mem_rdata;
    logic        stall_pc;
    logic        ignore_curr_inst;
    logic        mem_rw_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        misalign_err;

    modport master (
        output rs1_val, rs2_val, imm, store_control, mem_rdata,
        input  stall_pc, ignore_curr_inst, mem_rw_mode, mem_addr, mem_wdata, misalign_err
    );

    modport slave (
        input  rs1_val, rs2_val, imm, store_control, mem_rdata,
        output stall_pc, ignore_curr_inst, mem_rw_mode, mem_addr, mem_wdata, misalign_err
    );
endinterface

// File: rtl/store_unit.sv
// SB/SH/SW execution on a byte-enable-less single-port memory: sub-word stores
// read the word, replace one lane and write it back; SW writes directly.
module store_unit #(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    store_unit_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] MERGE = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;

    localparam logic [1:0] ST_NOP = 2'b00;
    localparam logic [1:0] ST_SB  = 2'b01;
    localparam logic [1:0] ST_SH  = 2'b10;
    localparam logic [1:0] ST_SW  = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [31:0] ea_q, ea_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  ctl_q, ctl_d;
    logic [31:0] merge_q, merge_d;

    logic [31:0] eaRaw;
    logic [31:0] eaFix;
    logic        misaligned;
    logic [31:0] laneMerged;

    // Truncation only matters when misaligned stores are allowed through.
    always_comb begin
        eaRaw      = bus.rs1_val + bus.imm;
        misaligned = ((bus.store_control == ST_SH) && eaRaw[0]) ||
                     ((bus.store_control == ST_SW) && (eaRaw[1:0] != 2'b00));
        eaFix      = eaRaw;
        if (bus.store_control == ST_SH) begin
            eaFix[0] = 1'b0;
        end else if (bus.store_control == ST_SW) begin
            eaFix[1:0] = 2'b00;
        end
    end

    always_comb begin
        laneMerged = bus.mem_rdata;
        if (ctl_q == ST_SB) begin
            laneMerged[{ea_q[1:0], 3'b000} +: 8] = data_q[7:0];
        end else begin
            laneMerged[{ea_q[1], 4'b0000} +: 16] = data_q;
        end
    end

    // Outputs fall back to NOP values while reset is held so an aborted store never writes.
    always_comb begin
        state_d              = state_q;
        ea_d                 = ea_q;
        data_d               = data_q;
        ctl_d                = ctl_q;
        merge_d              = merge_q;
        bus.stall_pc         = 1'b0;
        bus.ignore_curr_inst = 1'b0;
        bus.mem_rw_mode      = 1'b1;
        bus.mem_addr         = 32'h0;
        bus.mem_wdata        = 32'h0;
        bus.misalign_err     = 1'b0;
        if (i_rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.store_control != ST_NOP) begin
                        if (misaligned && ERR_ON_MISALIGN) begin
                            bus.misalign_err = 1'b1;
                        end else begin
                            bus.stall_pc = 1'b1;
                            bus.mem_addr = {eaFix[31:2], 2'b00};
                            ea_d         = eaFix;
                            data_d       = bus.rs2_val[15:0];
                            ctl_d        = bus.store_control;
                            if (bus.store_control == ST_SW) begin
                                merge_d = bus.rs2_val;
                                state_d = WRITE;
                            end else begin
                                state_d = MERGE;
                            end
                        end
                    end
                end
                MERGE: begin
                    bus.stall_pc         = 1'b1;
                    bus.ignore_curr_inst = 1'b1;
                    bus.mem_addr         = {ea_q[31:2], 2'b00};
                    merge_d              = laneMerged;
                    state_d              = WRITE;
                end
                WRITE: begin
                    bus.ignore_curr_inst = 1'b1;
                    bus.mem_rw_mode      = 1'b0;
                    bus.mem_addr         = {ea_q[31:2], 2'b00};
                    bus.mem_wdata        = merge_q;
                    state_d              = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            ea_q    <= 32'h0;
            data_q  <= 16'h0;
            ctl_q   <= ST_NOP;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            data_q  <= data_d;
            ctl_q   <= ctl_d;
            merge_q <= merge_d;
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: two instances (misaligned stores rejected / truncated) share
// the stimulus, each with its own word memory, checked every cycle against a store-level model.
module tb_store_unit;

    localparam logic [1:0] ST_NOP = 2'b00;
    localparam logic [1:0] ST_SB  = 2'b01;
    localparam logic [1:0] ST_SH  = 2'b10;
    localparam logic [1:0] ST_SW  = 2'b11;

    typedef struct {
        logic        stall;
        logic        ign;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        bit          chkAddr;
        bit          chkWdata;
    } exp_t;

    logic clock = 1'b0;
    logic rstN;

    store_unit_if bus0 ();
    store_unit_if bus1 ();

    store_unit #(.ERR_ON_MISALIGN(1'b1)) dutStrict (.i_clk(clock), .i_rst(rstN), .bus(bus0));
    store_unit #(.ERR_ON_MISALIGN(1'b0)) dutLoose  (.i_clk(clock), .i_rst(rstN), .bus(bus1));

    always #5 clock = ~clock;

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];
    logic [31:0] expMem0 [0:1023];
    logic [31:0] expMem1 [0:1023];
    logic        preloadEn = 1'b0;
    logic [31:0] preloadAddr, preloadData;
    int          writes0 = 0, writes1 = 0;
    int          expWrites0 = 0, expWrites1 = 0;

    // Synchronous memories: 1-cycle read latency, write commits on the edge.
    always @(posedge clock) begin
        if (preloadEn) begin
            mem0[preloadAddr[11:2]] <= preloadData;
            mem1[preloadAddr[11:2]] <= preloadData;
        end else begin
            if (!bus0.mem_rw_mode) mem0[bus0.mem_addr[11:2]] <= bus0.mem_wdata;
            if (!bus1.mem_rw_mode) mem1[bus1.mem_addr[11:2]] <= bus1.mem_wdata;
        end
        bus0.mem_rdata <= mem0[bus0.mem_addr[11:2]];
        bus1.mem_rdata <= mem1[bus1.mem_addr[11:2]];
        if (!bus0.mem_rw_mode) writes0 <= writes0 + 1;
        if (!bus1.mem_rw_mode) writes1 <= writes1 + 1;
    end

    int   checks = 0;
    int   errors = 0;
    bit   expOn  = 1'b0;
    exp_t exp0, exp1;
    exp_t seq0 [3];
    exp_t seq1 [3];

    function automatic exp_t mkExp(input logic stall, ign, rw, input logic [31:0] addr, wdata,
                                   input logic err, input bit ca, input bit cw);
        exp_t e;
        e.stall = stall; e.ign = ign; e.rw = rw; e.addr = addr; e.wdata = wdata;
        e.err = err; e.chkAddr = ca; e.chkWdata = cw;
        return e;
    endfunction

    function automatic exp_t idleExp();
        return mkExp(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    endfunction

    // Replace one byte or halfword lane of a word using plain shift/mask arithmetic.
    function automatic logic [31:0] laneMerge(input logic [31:0] old, input logic [1:0] ctl,
                                              input logic [31:0] ea, input logic [31:0] data);
        int          sh;
        logic [31:0] mask;
        if (ctl == ST_SB) begin
            sh   = 8 * int'(ea % 4);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((data & 32'hFF) << sh);
        end else if (ctl == ST_SH) begin
            sh   = 16 * int'((ea / 2) % 2);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((data & 32'hFFFF) << sh);
        end
        return data;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input logic stall, ign, rw,
                               input logic [31:0] addr, wdata, input logic err);
        checkVal({tag, ".stall_pc"}, {31'h0, stall}, {31'h0, e.stall});
        checkVal({tag, ".ignore"},   {31'h0, ign},   {31'h0, e.ign});
        checkVal({tag, ".rw_mode"},  {31'h0, rw},    {31'h0, e.rw});
        checkVal({tag, ".misalign"}, {31'h0, err},   {31'h0, e.err});
        if (e.chkAddr)  checkVal({tag, ".addr"},  addr,  e.addr);
        if (e.chkWdata) checkVal({tag, ".wdata"}, wdata, e.wdata);
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clock);
            if (expOn) begin
                checkOutput("dutStrict", exp0, bus0.stall_pc, bus0.ignore_curr_inst, bus0.mem_rw_mode,
                            bus0.mem_addr, bus0.mem_wdata, bus0.misalign_err);
                checkOutput("dutLoose", exp1, bus1.stall_pc, bus1.ignore_curr_inst, bus1.mem_rw_mode,
                            bus1.mem_addr, bus1.mem_wdata, bus1.misalign_err);
            end
        end
    endtask

    // Store-level model: per-cycle output sequence and the resulting memory word.
    task automatic modelStore(input int k, input logic [1:0] ctl, input logic [31:0] rs1, imm, rs2,
                              output int len);
        exp_t        s [3];
        logic [31:0] ea, word, oldv, newv;
        bit          mis;
        ea  = rs1 + imm;
        mis = ((ctl == ST_SH) && (ea % 2 != 0)) || ((ctl == ST_SW) && (ea % 4 != 0));
        for (int i = 0; i < 3; i++) s[i] = idleExp();
        if (ctl == ST_NOP) begin
            len = 1;
        end else if (mis && k == 0) begin
            len  = 1;
            s[0] = mkExp(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        end else begin
            if (mis) ea = ea - ea % ((ctl == ST_SH) ? 2 : 4);
            word = ea - ea % 4;
            oldv = (k == 0) ? expMem0[word[11:2]] : expMem1[word[11:2]];
            s[0] = mkExp(1'b1, 1'b0, 1'b1, word, 32'h0, 1'b0, 1'b1, 1'b0);
            if (ctl == ST_SW) begin
                len  = 2;
                newv = rs2;
                s[1] = mkExp(1'b0, 1'b1, 1'b0, word, newv, 1'b0, 1'b1, 1'b1);
            end else begin
                len  = 3;
                newv = laneMerge(oldv, ctl, ea, rs2);
                s[1] = mkExp(1'b1, 1'b1, 1'b1, word, 32'h0, 1'b0, 1'b1, 1'b0);
                s[2] = mkExp(1'b0, 1'b1, 1'b0, word, newv, 1'b0, 1'b1, 1'b1);
            end
            if (k == 0) begin
                expMem0[word[11:2]] = newv;
                expWrites0++;
            end else begin
                expMem1[word[11:2]] = newv;
                expWrites1++;
            end
        end
        if (k == 0) seq0 = s;
        else        seq1 = s;
    endtask

    task automatic setInputs(input logic [1:0] ctl, input logic [31:0] rs1, imm, rs2);
        bus0.store_control = ctl; bus0.rs1_val = rs1; bus0.imm = imm; bus0.rs2_val = rs2;
        bus1.store_control = ctl; bus1.rs1_val = rs1; bus1.imm = imm; bus1.rs2_val = rs2;
    endtask

    // Present one instruction for a cycle, then NOPs until both instances are idle again.
    task automatic applyStimulus(input logic [1:0] ctl, input logic [31:0] rs1, imm, rs2);
        int len0, len1, n;
        modelStore(0, ctl, rs1, imm, rs2, len0);
        modelStore(1, ctl, rs1, imm, rs2, len1);
        n = (len0 > len1) ? len0 : len1;
        for (int c = 0; c < n; c++) begin
            if (c == 0) setInputs(ctl, rs1, imm, rs2);
            else        setInputs(ST_NOP, 32'h0, 32'h0, 32'h0);
            exp0 = (c < len0) ? seq0[c] : idleExp();
            exp1 = (c < len1) ? seq1[c] : idleExp();
            @(posedge clock); #1;
        end
        setInputs(ST_NOP, 32'h0, 32'h0, 32'h0);
        exp0 = idleExp();
        exp1 = idleExp();
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        preloadEn   = 1'b1;
        preloadAddr = addr;
        preloadData = data;
        expMem0[addr[11:2]] = data;
        expMem1[addr[11:2]] = data;
        @(posedge clock); #1;
        preloadEn = 1'b0;
    endtask

    initial begin
        logic [31:0] touched [7];
        touched = '{32'h100, 32'h108, 32'h200, 32'h300, 32'h004, 32'h310, 32'h3F0};
        rstN = 1'b0;
        setInputs(ST_NOP, 32'h0, 32'h0, 32'h0);
        exp0  = idleExp();
        exp1  = idleExp();
        expOn = 1'b1;
        fork
            compareLoop();
        join_none

        checkVal("model.sb_lane", laneMerge(32'h11223344, ST_SB, 32'h202, 32'hAB), 32'h11AB3344);
        checkVal("model.sh_lane", laneMerge(32'h11223344, ST_SH, 32'h202, 32'h1234BEEF), 32'hBEEF3344);
        repeat (3) @(posedge clock);
        #1 rstN = 1'b1;

        preload(32'h200, 32'h11223344);
        preload(32'h004, 32'hCAFEF00D);
        preload(32'h300, 32'h55667788);
        preload(32'h3F0, 32'h13579BDF);

        applyStimulus(ST_SW, 32'h0000_00FC, 32'h4, 32'hDEADBEEF);
        checkVal("mem.sw_0x100", mem0[32'h100 >> 2], 32'hDEADBEEF);

        applyStimulus(ST_SB, 32'h200, 32'h2, 32'h0000_00AB);
        checkVal("mem.sb_0x202", mem0[32'h200 >> 2], 32'h11AB3344);

        preload(32'h200, 32'h11223344);
        applyStimulus(ST_SH, 32'h200, 32'h2, 32'h1234BEEF);
        checkVal("mem.sh_hi", mem0[32'h200 >> 2], 32'hBEEF3344);
        preload(32'h200, 32'h11223344);
        applyStimulus(ST_SH, 32'h200, 32'h0, 32'h1234BEEF);
        checkVal("mem.sh_lo", mem1[32'h200 >> 2], 32'h1122BEEF);

        applyStimulus(ST_SW, 32'h100, 32'h8, 32'h01020304);
        applyStimulus(ST_SB, 32'h300, 32'h1, 32'h0000_0099);
        applyStimulus(ST_SH, 32'h300, 32'h2, 32'h0000_7777);
        checkVal("mem.b2b_0x300", mem0[32'h300 >> 2], 32'h77779988);
        checkVal("mem.b2b_0x108", mem1[32'h108 >> 2], 32'h01020304);

        applyStimulus(ST_SW, 32'h100, 32'h2, 32'hA5A5A5A5);
        checkVal("mem.mis_strict", mem0[32'h100 >> 2], 32'hDEADBEEF);
        checkVal("mem.mis_loose",  mem1[32'h100 >> 2], 32'hA5A5A5A5);
        applyStimulus(ST_SH, 32'h200, 32'h3, 32'h0000_4321);
        checkVal("mem.mis_sh_strict", mem0[32'h200 >> 2], 32'h1122BEEF);
        checkVal("mem.mis_sh_loose",  mem1[32'h200 >> 2], 32'h4321BEEF);

        applyStimulus(ST_SB, 32'hFFFF_FFFC, 32'h8, 32'h0000_005A);
        checkVal("mem.wrap_0x004", mem0[32'h004 >> 2], 32'hCAFEF05A);

        // Abort an SB in its merge cycle with an asynchronous reset.
        setInputs(ST_SB, 32'h3F0, 32'h0, 32'h0000_0011);
        exp0 = mkExp(1'b1, 1'b0, 1'b1, 32'h3F0, 32'h0, 1'b0, 1'b1, 1'b0);
        exp1 = exp0;
        @(posedge clock); #1;
        setInputs(ST_NOP, 32'h0, 32'h0, 32'h0);
        exp0 = mkExp(1'b1, 1'b1, 1'b1, 32'h3F0, 32'h0, 1'b0, 1'b1, 1'b0);
        exp1 = exp0;
        @(negedge clock); #1;
        rstN = 1'b0;
        exp0 = idleExp();
        exp1 = idleExp();
        #1;
        checkOutput("rstStrict", exp0, bus0.stall_pc, bus0.ignore_curr_inst, bus0.mem_rw_mode,
                    bus0.mem_addr, bus0.mem_wdata, bus0.misalign_err);
        checkOutput("rstLoose", exp1, bus1.stall_pc, bus1.ignore_curr_inst, bus1.mem_rw_mode,
                    bus1.mem_addr, bus1.mem_wdata, bus1.misalign_err);
        repeat (2) @(posedge clock);
        #1 rstN = 1'b1;
        @(posedge clock); #1;
        checkVal("mem.abort_0x3F0", mem0[32'h3F0 >> 2], 32'h13579BDF);

        applyStimulus(ST_SW, 32'h300, 32'h10, 32'h0BADCAFE);
        checkVal("mem.after_rst", mem1[32'h310 >> 2], 32'h0BADCAFE);

        repeat (2) @(posedge clock);
        #1;
        expOn = 1'b0;
        checkVal("writes.strict", writes0, expWrites0);
        checkVal("writes.loose",  writes1, expWrites1);
        foreach (touched[i]) begin
            checkVal($sformatf("final.strict_%h", touched[i]), mem0[touched[i][11:2]], expMem0[touched[i][11:2]]);
            checkVal($sformatf("final.loose_%h", touched[i]),  mem1[touched[i][11:2]], expMem1[touched[i][11:2]]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
